// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor-control datapath.
//   bridge_state_e : H-bridge drive state (COAST, FWD, REV, DEAD)
//   calc_period    : PWM period in clocks from clock and carrier frequency
//   sat_abs        : magnitude of a signed duty word, clamped to a limit
package motor_pkg;

    localparam int unsigned DUTY_W = 24;
    localparam int unsigned ABS_W  = DUTY_W + 1;

    typedef enum logic [1:0] {
        COAST,
        FWD,
        REV,
        DEAD
    } bridge_state_e;

    // Carrier period in system clocks.
    function automatic int unsigned calc_period(input int unsigned clock_freq,
                                                input int unsigned pwm_freq);
        return clock_freq / pwm_freq;
    endfunction

    // One extra bit of width so the most negative duty has a representable magnitude.
    function automatic logic [ABS_W-1:0] sat_abs(input logic signed [DUTY_W-1:0] d,
                                                 input logic [ABS_W-1:0]         limit);
        logic [ABS_W-1:0] mag;
        mag = d[DUTY_W-1] ? (ABS_W'(0) - {d[DUTY_W-1], d}) : {1'b0, d};
        return (mag > limit) ? limit : mag;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Free-running PWM wrap counter.
//   clk_i          : system clock
//   rst_i          : synchronous active-high reset
//   cnt_o          : counter value, 0..PERIOD-1
//   boundary_o     : high in the clock where cnt_o == PERIOD-1
//   period_start_o : high in the clock where cnt_o == 0 (not in the clock right after reset)
module pwm_timebase #(
    parameter int unsigned PERIOD = 800,
    parameter int unsigned CNT_W  = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             boundary_o,
    output logic             period_start_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             boundary_q;
    logic             period_start_q;

    // Strobes are pre-decoded one count early so they line up with cnt_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q          <= '0;
            boundary_q     <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            if (cnt_q == CNT_W'(PERIOD - 1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            boundary_q     <= (cnt_q == CNT_W'(PERIOD - 2));
            period_start_q <= (cnt_q == CNT_W'(PERIOD - 1));
        end
    end

    assign cnt_o          = cnt_q;
    assign boundary_o     = boundary_q;
    assign period_start_o = period_start_q;

endmodule

// File: rtl/hbridge_pwm_driver.sv
// Two-input H-bridge driver with edge-aligned PWM, direction mapping,
// reversal dead time and enable/fault shutdown.
//   CLK           : system clock
//   reset         : synchronous active-high reset
//   duty          : signed duty word, sign = direction, magnitude in clocks
//   enable        : 1 allows driving, 0 forces coast
//   fault         : external driver fault, latched until reset
//   pwm_a / pwm_b : bridge IN1 (forward PWM) / IN2 (reverse PWM)
//   dir           : active direction, 0 forward, 1 reverse
//   period_start  : one-clock pulse at the start of each PWM period
//   fault_latched : sticky fault flag
module hbridge_pwm_driver
    import motor_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ  = 16_000_000,
    parameter int unsigned PWM_FREQ    = 20_000,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic signed [DUTY_W-1:0] duty,
    input  logic                     enable,
    input  logic                     fault,
    output logic                     pwm_a,
    output logic                     pwm_b,
    output logic                     dir,
    output logic                     period_start,
    output logic                     fault_latched
);

    localparam int unsigned PERIOD = calc_period(CLOCK_FREQ, PWM_FREQ);
    localparam int unsigned CNT_W  = $clog2(PERIOD);
    localparam int unsigned MAG_W  = $clog2(PERIOD + 1);
    localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             boundary;

    bridge_state_e    state_q;
    logic [MAG_W-1:0] mag_l_q;
    logic [MAG_W-1:0] mag_l_d;
    logic             req_dir_q;
    logic             req_dir_d;
    logic [DEAD_W-1:0] dead_cnt_q;
    logic             dir_q;
    logic             pwm_a_q;
    logic             pwm_b_q;
    logic             fault_latched_q;

    logic             pwm_on_c;
    logic             mag_nz_c;
    logic             stop_c;

    pwm_timebase #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_timebase (
        .clk_i          (CLK),
        .rst_i          (reset),
        .cnt_o          (cnt),
        .boundary_o     (boundary),
        .period_start_o (period_start)
    );

    // Values that get latched at the period boundary; transitions taken at the
    // boundary act on these so the new period starts with the new request.
    assign mag_l_d   = MAG_W'(sat_abs(duty, ABS_W'(PERIOD)));
    assign req_dir_d = duty[DUTY_W-1];
    assign mag_nz_c  = (mag_l_d != '0);

    assign pwm_on_c  = (MAG_W'(cnt) < mag_l_q);

    // Shutdown has priority over any boundary transition in the same clock.
    assign stop_c    = fault || fault_latched_q || !enable;

    // Direction / dead-time FSM with registered bridge outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q         <= COAST;
            mag_l_q         <= '0;
            req_dir_q       <= 1'b0;
            dead_cnt_q      <= '0;
            dir_q           <= 1'b0;
            pwm_a_q         <= 1'b0;
            pwm_b_q         <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            pwm_a_q    <= 1'b0;
            pwm_b_q    <= 1'b0;
            dead_cnt_q <= '0;

            if (boundary) begin
                mag_l_q   <= mag_l_d;
                req_dir_q <= req_dir_d;
            end

            if (fault) begin
                fault_latched_q <= 1'b1;
            end

            if (stop_c) begin
                state_q <= COAST;
            end else begin
                case (state_q)
                    COAST: begin
                        if (boundary && mag_nz_c) begin
                            state_q <= req_dir_d ? REV : FWD;
                            dir_q   <= req_dir_d;
                        end
                    end
                    FWD: begin
                        pwm_a_q <= pwm_on_c;
                        if (boundary) begin
                            if (!mag_nz_c) begin
                                state_q <= COAST;
                            end else if (req_dir_d) begin
                                state_q <= DEAD;
                            end
                        end
                    end
                    REV: begin
                        pwm_b_q <= pwm_on_c;
                        if (boundary) begin
                            if (!mag_nz_c) begin
                                state_q <= COAST;
                            end else if (!req_dir_d) begin
                                state_q <= DEAD;
                            end
                        end
                    end
                    DEAD: begin
                        // Counter keeps its phase, so the first pulse after DEAD is short.
                        if (dead_cnt_q == DEAD_LAST) begin
                            if (mag_l_q == '0) begin
                                state_q <= COAST;
                            end else begin
                                state_q <= req_dir_q ? REV : FWD;
                                dir_q   <= req_dir_q;
                            end
                        end else begin
                            dead_cnt_q <= dead_cnt_q + DEAD_W'(1);
                        end
                    end
                    default: begin
                        state_q <= COAST;
                    end
                endcase
            end
        end
    end

    assign pwm_a         = pwm_a_q;
    assign pwm_b         = pwm_b_q;
    assign dir           = dir_q;
    assign fault_latched = fault_latched_q;

endmodule

// File: doc/hbridge_pwm_driver.md
Name: hbridge_pwm_driver

Overview:
Downstream stage of the PID motor controller. Consumes the signed 24-bit duty word and drives a two-input H-bridge (IN1/IN2 style) with fixed-frequency edge-aligned PWM. Adds sign-to-direction mapping, magnitude saturation, period-synchronous duty update, dead time on direction reversal, and an enable/fault shutdown path.

Parameters:
CLOCK_FREQ, 16_000_000, system clock in Hz.
PWM_FREQ, 20_000, PWM carrier frequency in Hz; PERIOD = CLOCK_FREQ/PWM_FREQ (800 at defaults).
DEAD_CYCLES, 16, clocks with both outputs low on a direction reversal; must be less than PERIOD.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
duty  input  24  signed duty from the PID controller; sign gives direction, magnitude in clock counts.
enable  input  1  1 = bridge allowed to drive; 0 = coast.
fault  input  1  external driver fault, active-high.
pwm_a  output  1  H-bridge IN1; carries PWM in forward direction.
pwm_b  output  1  H-bridge IN2; carries PWM in reverse direction.
dir  output  1  active direction: 0 = forward (duty >= 0), 1 = reverse.
period_start  output  1  one-clock pulse when cnt == 0.
fault_latched  output  1  sticky fault flag.

Behaviour:
- Reset (sync, active-high): cnt = 0, mag_l = 0, dir = 0, state = COAST, pwm_a = pwm_b = 0, period_start = 0, fault_latched = 0. A reset mid-period takes effect on the next edge; no partial pulse follows.
- Timebase: cnt runs 0..PERIOD-1 and wraps to 0. The counter runs in all states. period_start is registered high for the clock in which cnt == 0.
- Magnitude: abs(duty) is computed in 25-bit arithmetic, so -8388608 gives 8388608 with no overflow. The result is clamped to PERIOD.
- Duty latch: when cnt == PERIOD-1, mag_l and the requested direction (req_dir = duty[23]) are latched. New values take effect from cnt == 0. A duty change mid-period has no effect until the next boundary.
- Compare: pwm_on = (cnt < mag_l). mag_l == 0 gives constant low. mag_l == PERIOD gives constant high.
- Outputs are registered, one clock after the compare.
- States:
  - COAST: both outputs 0. At a boundary with mag_l != 0 and enable = 1 and no fault: go to FWD or REV per req_dir. The first entry after reset or coast has no dead time.
  - FWD: pwm_a = pwm_on, pwm_b = 0. At a boundary: if mag_l == 0, go to COAST. If req_dir = 1, go to DEAD.
  - REV: pwm_b = pwm_on, pwm_a = 0. Mirror of FWD.
  - DEAD: both 0, dead counter counts DEAD_CYCLES clocks, then enter FWD/REV per req_dir.
    - The counter is not phase-realigned, so the first pulse after DEAD is truncated (high for cnt in [DEAD_CYCLES, mag_l)).
    - A boundary during DEAD re-evaluates req_dir. If req_dir is back to the pre-DEAD direction, DEAD still completes.
- dir updates when FWD or REV is entered. It holds its value in COAST and DEAD.
- pwm_a and pwm_b are never both 1 in the same cycle; this is an invariant, asserted in verification.
- enable = 0: next clock both outputs 0, state = COAST. Resumption happens only at a period boundary.
- fault = 1: next clock both outputs 0, state = COAST, fault_latched = 1. While fault_latched = 1 the block stays in COAST regardless of enable or fault. Only reset clears fault_latched.
- Simultaneous fault and boundary in the same cycle: fault wins.

Decomposition:
- Shared package motor_pkg: state enum (COAST, FWD, REV, DEAD), function computing PERIOD from CLOCK_FREQ/PWM_FREQ, saturating abs function for 24-bit signed values.
- One sub-module, pwm_timebase: parameterised wrap counter producing cnt, the boundary strobe (cnt == PERIOD-1) and period_start.
- Direction/dead-time FSM, compare and output registers stay in the top module.

Test Plan:
1. duty = 400, enable = 1 after reset -> from second period, pwm_a high 400 of every 800 clocks, pwm_b = 0, dir = 0, period_start every 800 clocks.
2. Running at duty = 400, change to -200 mid-period -> unchanged until boundary; then both low 16 clocks; then pwm_b high for cnt 16..199; dir = 1 from then; full 200-clock pulses afterwards.
3. duty = 5000 -> pwm_a constantly high. duty = -8388608 -> pwm_b constantly high after 16-clock dead time, no overflow.
4. duty = 0 while in FWD -> COAST at next boundary, both outputs low, dir stays 0.
5. fault pulsed for 1 clock mid-pulse -> both outputs low next clock, fault_latched = 1, stays off with enable = 1. After reset, normal PWM resumes.
6. reset asserted at cnt = 300 during a high pulse -> next clock pwm_a = 0 and cnt = 0. With duty = 400 held, the first pulse starts only after the next boundary, since COAST is the reset state.
